// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, multiplier state encoding
// and the two's-complement magnitude helper.
package alu_pkg;

  localparam int W  = 8;
  localparam int NW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  // 0x80 maps to 0x80, read as unsigned 128
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/nibble_pp.sv
// Combinational 8x4 unsigned partial product,
// built as a sum of gated, shifted copies of the multiplicand.
module nibble_pp
  import alu_pkg::*;
(
  input  logic [W-1:0]    a,
  input  logic [NW-1:0]   n,
  output logic [W+NW-1:0] p
);

  logic [W+NW-1:0] a_ext;

  assign a_ext = {{NW{1'b0}}, a};

  always_comb begin
    p = '0;
    for (int i = 0; i < NW; i++) begin
      if (n[i]) p = p + (a_ext << i);
    end
  end

endmodule

// File: rtl/mul8_seq.sv
// Multi-cycle 8x8 -> 16 multiplier: two nibble passes over one
// partial-product unit, then sign fix-up into the output registers.
module mul8_seq
  import alu_pkg::*;
#(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    SIGNED_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] Input_1,
  input  logic [W-1:0] Input_2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Output_lo,
  output logic [W-1:0] Output_hi
);

  state_e            state_q, state_d;
  logic [W-1:0]      mag_a_q, mag_a_d;
  logic [W-1:0]      mag_b_q, mag_b_d;
  logic              neg_q, neg_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [2*W-1:0]    res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sm;
  logic [NW-1:0]     nib;
  logic [W+NW-1:0]   pp;

  assign sm  = signed_mode & (SIGNED_EN != 0);
  assign nib = (state_q == S_HI) ? mag_b_q[W-1:NW] : mag_b_q[NW-1:0];

  nibble_pp u_pp (
    .a (mag_a_q),
    .n (nib),
    .p (pp)
  );

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_a_d = sm ? mag(Input_1) : Input_1;
          mag_b_d = sm ? mag(Input_2) : Input_2;
          neg_d   = sm & (Input_1[W-1] ^ Input_2[W-1]);
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LO;
        end
      end
      S_LO: begin
        acc_d   = {{NW{1'b0}}, pp};
        state_d = S_HI;
      end
      S_HI: begin
        acc_d   = acc_q + {pp, {NW{1'b0}}};
        state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = neg_q ? (~acc_q + 1'b1) : acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Output_lo = res_q[W-1:0];
  assign Output_hi = res_q[2*W-1:W];

endmodule

// File: tb/tb_mul8_seq.sv
// Directed and random checks of mul8_seq, signed-capable and
// unsigned-only instances driven side by side.
module tb_mul8_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sm = 1'b0;
  logic [7:0] in1 = '0;
  logic [7:0] in2 = '0;

  logic       busy1, done1, busy0, done0;
  logic [7:0] lo1, hi1, lo0, hi0;

  int total = 0;
  int bad   = 0;

  logic [15:0] last1 = '0;
  logic [15:0] last0 = '0;

  always #5 clk = ~clk;

  mul8_seq #(.UUID(1), .NAME("mul_s"), .SIGNED_EN(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
    .Input_1(in1), .Input_2(in2),
    .busy(busy1), .done(done1), .Output_lo(lo1), .Output_hi(hi1)
  );

  mul8_seq #(.UUID(2), .NAME("mul_u"), .SIGNED_EN(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
    .Input_1(in1), .Input_2(in2),
    .busy(busy0), .done(done0), .Output_lo(lo0), .Output_hi(hi0)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic s);
    int ia, ib;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    return 16'(ia * ib);
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic s, input string tag);
    int k;
    @(negedge clk);
    start = 1'b1; in1 = a; in2 = b; sm = s;
    @(negedge clk);
    start = 1'b0;
    in1 = ~a; in2 = ~b; sm = ~s;
    k = 1;
    while (!done1 && k < 8) begin
      check({tag, "_busy"}, {15'd0, busy1}, 16'd1);
      check({tag, "_hold"}, {hi1, lo1}, last1);
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, {15'd0, done1}, 16'd1);
    check({tag, "_lat"}, 16'(k - 1), 16'd3);
    check({tag, "_busy_done"}, {15'd0, busy1}, 16'd0);
    last1 = ref_mul(a, b, s);
    last0 = ref_mul(a, b, 1'b0);
    check({tag, "_prod"}, {hi1, lo1}, last1);
    check({tag, "_prod_u"}, {hi0, lo0}, last0);
    @(negedge clk);
    check({tag, "_pulse"}, {15'd0, done1}, 16'd0);
  endtask

  logic [7:0] opa [0:63];
  logic [7:0] opb [0:63];
  logic       ops [0:63];

  initial begin
    int nd, ac;
    // reset with start held high
    rst = 1'b0; start = 1'b1; in1 = 8'h55; in2 = 8'h66;
    repeat (2) @(negedge clk);
    check("rst_busy", {15'd0, busy1}, 16'd0);
    check("rst_done", {15'd0, done1}, 16'd0);
    check("rst_out", {hi1, lo1}, 16'h0000);
    check("rst_out_u", {hi0, lo0}, 16'h0000);
    start = 1'b0; rst = 1'b1;
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      nd += int'(done1);
    end
    check("rst_nodone", 16'(nd), 16'd0);

    do_op(8'hFF, 8'hFF, 1'b0, "uns_ff");
    check("uns_ff_val", {hi1, lo1}, 16'hFE01);
    do_op(8'hFD, 8'h05, 1'b1, "sgn_m3x5");
    check("sgn_m3x5_val", {hi1, lo1}, 16'hFFF1);
    do_op(8'h80, 8'h80, 1'b1, "sgn_80x80");
    check("sgn_80x80_val", {hi1, lo1}, 16'h4000);
    check("uen_80x80_val", {hi0, lo0}, 16'h4000);
    do_op(8'h80, 8'h03, 1'b1, "sgn_80x03");
    check("sgn_80x03_val", {hi1, lo1}, 16'hFE80);
    check("uen_80x03_val", {hi0, lo0}, 16'h0180);

    // start pulse mid-operation must be ignored
    @(negedge clk);
    start = 1'b1; in1 = 8'h0B; in2 = 8'h0D; sm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; in1 = 8'hAA; in2 = 8'hBB;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ign_done", {15'd0, done1}, 16'd1);
    check("ign_prod", {hi1, lo1}, 16'h008F);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      nd += int'(done1);
    end
    check("ign_nodone", 16'(nd), 16'd0);
    last1 = 16'h008F;
    last0 = 16'h008F;

    // reset during HI
    @(negedge clk);
    start = 1'b1; in1 = 8'h12; in2 = 8'h34; sm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_out", {hi1, lo1}, 16'h0000);
    check("mrst_busy", {15'd0, busy1}, 16'd0);
    check("mrst_done", {15'd0, done1}, 16'd0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      nd += int'(done1);
    end
    check("mrst_nodone", 16'(nd), 16'd0);
    last1 = '0;
    last0 = '0;
    do_op(8'h12, 8'h34, 1'b0, "mrst_redo");
    check("mrst_redo_val", {hi1, lo1}, 16'h03A8);

    // start held high with operands changing every cycle
    for (int i = 0; i < 64; i++) begin
      opa[i] = 8'($urandom);
      opb[i] = 8'($urandom);
      ops[i] = 1'($urandom);
    end
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n > 0 && done1) begin
        nd++;
        ac = n - 4;
        if (ac < 0) ac = 0;
        check("b2b_prod", {hi1, lo1},
              ref_mul(opa[ac], opb[ac], ops[ac]));
        check("b2b_prod_u", {hi0, lo0},
              ref_mul(opa[ac], opb[ac], 1'b0));
      end
      start = 1'b1;
      in1 = opa[n]; in2 = opb[n]; sm = ops[n];
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b_count", 16'(nd >= 9), 16'd1);
    repeat (6) @(negedge clk);
    last1 = {hi1, lo1};
    last0 = {hi0, lo0};

    for (int r = 0; r < 1000; r++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
